// File: rtl/uno_pkg.sv
// Shared UNO card definitions used by the deck, hand and rules blocks.
package uno_pkg;

    localparam int CARD_W = 6;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2,
        BLUE   = 2'd3
    } color_t;

    typedef struct packed {
        color_t     color;
        logic [3:0] value;
    } card_t;

    localparam logic [3:0] SKIP    = 4'd10;
    localparam logic [3:0] REVERSE = 4'd11;
    localparam logic [3:0] DRAW2   = 4'd12;
    localparam logic [3:0] WILD    = 4'd13;
    localparam logic [3:0] WILD4   = 4'd14;

    localparam logic [2:0] DRAW_ONE  = 3'b001;
    localparam logic [2:0] DRAW_TWO  = 3'b010;
    localparam logic [2:0] DRAW_FOUR = 3'b100;

endpackage

// File: rtl/uno_hand_buffer_if.sv
// Command, deck and read-port signals of the hand buffer; master = game control side.
interface uno_hand_buffer_if #(
    parameter int IDX_W = 5,
    parameter int CNT_W = 6
);
    logic [2:0]                 i_draw_req;
    logic                       i_play;
    logic [IDX_W-1:0]           i_play_idx;
    logic [IDX_W-1:0]           i_sel_idx;
    logic                       i_deck_done;
    logic                       i_deck_drawn;
    logic [uno_pkg::CARD_W-1:0] i_deck_card;
    logic [2:0]                 o_deck_draw;
    logic [uno_pkg::CARD_W-1:0] o_sel_card;
    logic [uno_pkg::CARD_W-1:0] o_played_card;
    logic [CNT_W-1:0]           o_count;
    logic                       o_busy;
    logic                       o_draw_done;
    logic                       o_play_done;
    logic                       o_err;

    modport master (
        output i_draw_req, i_play, i_play_idx, i_sel_idx,
               i_deck_done, i_deck_drawn, i_deck_card,
        input  o_deck_draw, o_sel_card, o_played_card, o_count,
               o_busy, o_draw_done, o_play_done, o_err
    );

    modport slave (
        input  i_draw_req, i_play, i_play_idx, i_sel_idx,
               i_deck_done, i_deck_drawn, i_deck_card,
        output o_deck_draw, o_sel_card, o_played_card, o_count,
               o_busy, o_draw_done, o_play_done, o_err
    );
endinterface

// File: rtl/uno_hand_buffer.sv
// Per-player compacted hand store: turns draw pulses into held deck requests,
// appends drawn cards and removes played cards with one-entry-per-cycle compaction.
module uno_hand_buffer
    import uno_pkg::*;
#(
    parameter int MAX_CARDS = 32,
    parameter int IDX_W     = 5,
    parameter int CNT_W     = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    uno_hand_buffer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DECK = 2'd1,
        DRAW      = 2'd2,
        SHIFT     = 2'd3
    } state_t;

    localparam logic [CNT_W:0] MAX_X = (CNT_W+1)'(MAX_CARDS);

    state_t           state_q, state_d;
    logic [2:0]       req_q, req_d;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    card_t            hand_q [MAX_CARDS];
    card_t            hand_d [MAX_CARDS];
    card_t            played_q, played_d;
    logic             draw_done_q, draw_done_d;
    logic             play_done_q, play_done_d;
    logic             err_q, err_d;

    logic [CNT_W:0]   draw_sum;
    logic [CNT_W-1:0] cnt_m1;
    logic [IDX_W-1:0] ptr_p1;

    // The one-hot request encodes its own card count (001=1, 010=2, 100=4).
    assign draw_sum = {1'b0, cnt_q} + (CNT_W+1)'(bus.i_draw_req);
    assign cnt_m1   = cnt_q - 1'b1;
    assign ptr_p1   = ptr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        hand_d      = hand_q;
        played_d    = played_q;
        draw_done_d = 1'b0;
        play_done_d = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_draw_req != 3'b000) begin
                    if (!$onehot(bus.i_draw_req) || draw_sum > MAX_X) begin
                        err_d = 1'b1;
                    end else begin
                        req_d   = bus.i_draw_req;
                        rem_d   = bus.i_draw_req;
                        state_d = WAIT_DECK;
                    end
                end else if (bus.i_play) begin
                    if (cnt_q == '0 || CNT_W'(bus.i_play_idx) >= cnt_q) begin
                        err_d = 1'b1;
                    end else begin
                        played_d = hand_q[bus.i_play_idx];
                        ptr_d    = bus.i_play_idx;
                        state_d  = SHIFT;
                    end
                end
            end
            WAIT_DECK: begin
                if (bus.i_deck_done) state_d = DRAW;
            end
            DRAW: begin
                if (bus.i_deck_drawn) begin
                    hand_d[cnt_q[IDX_W-1:0]] = card_t'(bus.i_deck_card);
                    cnt_d = cnt_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == 3'd1) begin
                        state_d     = IDLE;
                        draw_done_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (CNT_W'(ptr_q) < cnt_m1) begin
                    hand_d[ptr_q] = hand_q[ptr_p1];
                    ptr_d         = ptr_p1;
                end else begin
                    hand_d[cnt_m1[IDX_W-1:0]] = '0;
                    cnt_d       = cnt_m1;
                    state_d     = IDLE;
                    play_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            ptr_q       <= '0;
            hand_q      <= '{default: '0};
            played_q    <= '0;
            draw_done_q <= 1'b0;
            play_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            hand_q      <= hand_d;
            played_q    <= played_d;
            draw_done_q <= draw_done_d;
            play_done_q <= play_done_d;
            err_q       <= err_d;
        end
    end

    // Request is derived from state so it drops the instant reset forces IDLE.
    assign bus.o_deck_draw   = (state_q == DRAW) ? req_q : 3'b000;
    assign bus.o_sel_card    = (CNT_W'(bus.i_sel_idx) < cnt_q) ? hand_q[bus.i_sel_idx] : '0;
    assign bus.o_played_card = played_q;
    assign bus.o_count       = cnt_q;
    assign bus.o_busy        = (state_q != IDLE);
    assign bus.o_draw_done   = draw_done_q;
    assign bus.o_play_done   = play_done_q;
    assign bus.o_err         = err_q;

endmodule
